// File: rtl/tetris_pkg.sv
// Shared board geometry defaults, FSM state and cell classification types
// for the tetron collision checker.
package tetris_pkg;

  localparam int BOARD_W_DEF = 10;
  localparam int BOARD_H_DEF = 20;
  localparam int OFS_W_DEF   = 5;
  localparam int COORD_W     = 7;
  localparam int ADDR_W      = 8;
  localparam int NUM_BLK     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    IN    = 2'd0,
    ABOVE = 2'd1,
    OUT   = 2'd2
  } cell_cls_t;

endpackage

// File: rtl/tetron_cell_locator.sv
// Combinational: absolute coordinates of one block, its bounds class and
// its linear board index. Offsets narrower than COORD_W are sign-extended.
module tetron_cell_locator
  import tetris_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int BOARD_H = BOARD_H_DEF,
  parameter int OFS_W   = OFS_W_DEF
) (
  input  logic [4:0]        row,
  input  logic [3:0]        col,
  input  logic [OFS_W-1:0]  voffset,
  input  logic [OFS_W-1:0]  hoffset,
  output cell_cls_t         cls,
  output logic [ADDR_W-1:0] idx
);

  localparam logic signed [COORD_W-1:0] W_S = COORD_W'(BOARD_W);
  localparam logic signed [COORD_W-1:0] H_S = COORD_W'(BOARD_H);

  logic signed [COORD_W-1:0] abs_row;
  logic signed [COORD_W-1:0] abs_col;
  logic [15:0]               lin;

  // 7-bit signed sums cannot overflow: row<=31, col<=15, offsets within +/-32.
  always_comb begin
    abs_row = $signed({2'b00, row}) +
              $signed({{(COORD_W-OFS_W){voffset[OFS_W-1]}}, voffset});
    abs_col = $signed({3'b000, col}) +
              $signed({{(COORD_W-OFS_W){hoffset[OFS_W-1]}}, hoffset});
  end

  always_comb begin
    lin = 16'(abs_row[COORD_W-1:0]) * 16'(BOARD_W) + 16'(abs_col[COORD_W-1:0]);
    idx = lin[ADDR_W-1:0];
  end

  // Side walls and floor win over "above": a block off the side is a hit
  // even if it is also above the board.
  always_comb begin
    if (abs_col[COORD_W-1] || (abs_col >= W_S) || (abs_row >= H_S)) begin
      cls = OUT;
    end else if (abs_row[COORD_W-1]) begin
      cls = ABOVE;
    end else begin
      cls = IN;
    end
  end

endmodule

// File: rtl/tetron_collision_checker.sv
// Checks one four-block piece placement against the board RAM, one block at
// a time with early exit on the first wall/floor hit or occupied cell.
module tetron_collision_checker
  import tetris_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int BOARD_H = BOARD_H_DEF,
  parameter int OFS_W   = OFS_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4:0]        piece_row,
  input  logic [3:0]        piece_col,
  input  logic [OFS_W-1:0]  blk1_voffset,
  input  logic [OFS_W-1:0]  blk1_hoffset,
  input  logic [OFS_W-1:0]  blk2_voffset,
  input  logic [OFS_W-1:0]  blk2_hoffset,
  input  logic [OFS_W-1:0]  blk3_voffset,
  input  logic [OFS_W-1:0]  blk3_hoffset,
  input  logic [OFS_W-1:0]  blk4_voffset,
  input  logic [OFS_W-1:0]  blk4_hoffset,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_data,
  output logic              busy,
  output logic              done,
  output logic              collide
);

  state_t            state_q, state_d;
  logic [2:0]        blk_q, blk_d;
  logic              collide_q, collide_d;
  logic              ld;

  logic [4:0]        row_q;
  logic [3:0]        col_q;
  logic [OFS_W-1:0]  voff_q [NUM_BLK];
  logic [OFS_W-1:0]  hoff_q [NUM_BLK];
  logic [OFS_W-1:0]  voff_in [NUM_BLK];
  logic [OFS_W-1:0]  hoff_in [NUM_BLK];

  logic [1:0]        blk_sel;
  logic              last_blk;
  cell_cls_t         cls;
  logic [ADDR_W-1:0] idx;

  always_comb begin
    voff_in[0] = blk1_voffset;
    voff_in[1] = blk2_voffset;
    voff_in[2] = blk3_voffset;
    voff_in[3] = blk4_voffset;
    hoff_in[0] = blk1_hoffset;
    hoff_in[1] = blk2_hoffset;
    hoff_in[2] = blk3_hoffset;
    hoff_in[3] = blk4_hoffset;
  end

  // Block index runs 1..4; the low two bits minus one give the array slot.
  assign blk_sel  = blk_q[1:0] - 2'd1;
  assign last_blk = (blk_q == 3'd4);

  tetron_cell_locator #(
    .BOARD_W (BOARD_W),
    .BOARD_H (BOARD_H),
    .OFS_W   (OFS_W)
  ) u_locator (
    .row     (row_q),
    .col     (col_q),
    .voffset (voff_q[blk_sel]),
    .hoffset (hoff_q[blk_sel]),
    .cls     (cls),
    .idx     (idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      blk_q     <= 3'd1;
      collide_q <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      for (int i = 0; i < NUM_BLK; i++) begin
        voff_q[i] <= '0;
        hoff_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      blk_q     <= blk_d;
      collide_q <= collide_d;
      if (ld) begin
        row_q <= piece_row;
        col_q <= piece_col;
        for (int i = 0; i < NUM_BLK; i++) begin
          voff_q[i] <= voff_in[i];
          hoff_q[i] <= hoff_in[i];
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    blk_d     = blk_q;
    collide_d = collide_q;
    ld        = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ld        = 1'b1;
          collide_d = 1'b0;
          blk_d     = 3'd1;
          state_d   = CHECK;
        end
      end
      CHECK: begin
        case (cls)
          OUT: begin
            collide_d = 1'b1;
            state_d   = DONE;
          end
          ABOVE: begin
            if (last_blk) state_d = DONE;
            else          blk_d   = blk_q + 3'd1;
          end
          IN: begin
            rd_en   = 1'b1;
            rd_addr = idx;
            state_d = WAIT;
          end
          default: state_d = DONE;
        endcase
      end
      WAIT: begin
        if (rd_data) begin
          collide_d = 1'b1;
          state_d   = DONE;
        end else if (last_blk) begin
          state_d = DONE;
        end else begin
          blk_d   = blk_q + 3'd1;
          state_d = CHECK;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign collide = collide_q;

endmodule
